// File: rtl/key_load_pkg.sv
// Shared types and constants for the key-load controller: FSM encoding and
// the byte layout of a key-store transfer (key bytes followed by one checksum).
package key_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ARMED,
        ST_FAULT
    } state_t;

    localparam int KEY_W_DEFAULT = 32;
    localparam int KEY_BYTES     = KEY_W_DEFAULT / 8;
    localparam int CHK_IDX       = KEY_BYTES;

    // Key bytes for a given key width; the checksum byte follows the last one.
    function automatic int key_bytes(input int key_w);
        return key_w / 8;
    endfunction

    function automatic int chk_index(input int key_w);
        return key_w / 8;
    endfunction

endpackage

// File: rtl/key_load_ctrl.sv
// Loads a key byte-serially from the key store, verifies its XOR checksum and
// only then exposes it on key_o; any fault, reload or zeroize hides the key.
module key_load_ctrl
    import key_load_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             zeroize,
    input  logic             ks_valid,
    input  logic [7:0]       ks_data,
    output logic             ks_ready,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int NB    = key_bytes(KEY_W);
    localparam int CHK   = chk_index(KEY_W);
    localparam int CNT_W = $clog2(CHK + 1);
    localparam logic [CNT_W-1:0] CHK_CNT = CNT_W'(CHK);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shadow_q;
    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [7:0]       to_cnt_q;
    logic [7:0]       xor_q;
    logic             xfer;
    logic             load_entry;

    assign xfer       = ks_valid && ks_ready;
    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (zeroize) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (xfer && byte_cnt_q == CHK_CNT) state_d = ST_CHECK;
                    else if (!xfer && to_cnt_q == TO_LAST) state_d = ST_FAULT;
                end
                ST_CHECK: state_d = (xor_q == 8'h00) ? ST_ARMED : ST_FAULT;
                ST_ARMED: if (start) state_d = ST_LOAD;
                ST_FAULT: if (start) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // zeroize also drops ks_ready so a byte offered that cycle is never taken.
    always_comb begin
        ks_ready  = (state_q == ST_LOAD) && !zeroize;
        busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
        err       = (state_q == ST_FAULT);
        key_valid = (state_q == ST_ARMED);
        key_o     = key_q;
    end

    // NOTE: the shadow is key material, so it is reset and cleared like every
    // other register rather than left holding old bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            key_q      <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            xor_q      <= '0;
        end else if (zeroize || load_entry) begin
            shadow_q   <= '0;
            key_q      <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            xor_q      <= '0;
        end else if (state_q == ST_LOAD) begin
            if (xfer) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) shadow_q[8*i +: 8] <= ks_data;
                end
                byte_cnt_q <= byte_cnt_q + 1'b1;
                xor_q      <= xor_q ^ ks_data;
                to_cnt_q   <= '0;
            end else begin
                to_cnt_q   <= to_cnt_q + 8'd1;
            end
        end else if (state_q == ST_CHECK && xor_q == 8'h00) begin
            // Key bytes XOR checksum is zero exactly when the checksum matches.
            key_q <= shadow_q;
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl: directed loads with a scoreboard of
// expected outcomes (armed key or fault) popped when the DUT settles.
module tb_key_load_ctrl;

    localparam int KEY_W = 32;
    localparam int TO    = 8;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             zeroize  = 1'b0;
    logic             ks_valid = 1'b0;
    logic [7:0]       ks_data  = 8'h00;
    logic             ks_ready;
    logic [KEY_W-1:0] key_o;
    logic             key_valid;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit               fault;
        logic [KEY_W-1:0] key;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic kv_prev  = 1'b0;
    logic err_prev = 1'b0;

    always #5 clk = ~clk;

    key_load_ctrl #(.KEY_W(KEY_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .zeroize   (zeroize),
        .ks_valid  (ks_valid),
        .ks_data   (ks_data),
        .ks_ready  (ks_ready),
        .key_o     (key_o),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] key_xor(input logic [KEY_W-1:0] k);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < KEY_W / 8; i++) x ^= k[8*i +: 8];
        return x;
    endfunction

    // Scoreboard consumer: each settled outcome pops one expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            kv_prev  = 1'b0;
            err_prev = 1'b0;
        end else begin
            if (key_valid && !kv_prev) begin
                if (sb_q.size() == 0) check("sb_unexpected_arm", 1, 0);
                else begin
                    mon_e = sb_q.pop_front();
                    check("sb_arm_kind", 0, mon_e.fault);
                    check("sb_arm_key", key_o, mon_e.key);
                end
            end
            if (err && !err_prev) begin
                if (sb_q.size() == 0) check("sb_unexpected_fault", 1, 0);
                else begin
                    mon_e = sb_q.pop_front();
                    check("sb_fault_kind", 1, mon_e.fault);
                    check("sb_fault_key", key_o, 0);
                end
            end
            kv_prev  = key_valid;
            err_prev = err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ks_valid = 1'b1;
        ks_data  = b;
        @(negedge clk);
        while (!ks_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ks_ready) check("ks_ready_timeout", 0, 1);
        tick();
        ks_valid = 1'b0;
    endtask

    // Full load of key bytes plus checksum; start_at >= 0 injects a start
    // (which must be ignored) before that byte index.
    task automatic send_load(input logic [KEY_W-1:0] k, input logic [7:0] chk, input int start_at);
        exp_t e;
        e.fault = (chk != key_xor(k));
        e.key   = k;
        sb_q.push_back(e);
        for (int i = 0; i < KEY_W / 8; i++) begin
            if (i == start_at) begin
                start_pulse();
                check("start_in_load_busy", busy, 1);
            end
            send_byte(k[8*i +: 8]);
        end
        send_byte(chk);
        check("chk_edge_kv", key_valid, 0);
        check("chk_edge_key", key_o, 0);
        check("chk_edge_busy", busy, 1);
        tick();
        if (e.fault) begin
            check("load_err", err, 1);
            check("load_fault_key", key_o, 0);
        end else begin
            check("load_kv", key_valid, 1);
            check("load_key", key_o, k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_key", key_o, 0);
        check("rst_kv", key_valid, 0);
        check("rst_ready", ks_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        #20 rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_ready", ks_ready, 0);

        // Basic load, ks_valid held high across bytes.
        start_pulse();
        check("load_busy", busy, 1);
        check("load_ready", ks_ready, 1);
        send_load(32'hA5C31E7F, 8'h07, -1);

        // Reload from ARMED with a bad checksum, then retry from FAULT.
        start_pulse();
        check("rearm_key_clear", key_o, 0);
        check("rearm_kv_clear", key_valid, 0);
        send_load(32'hA5C31E7F, 8'h08, -1);
        start_pulse();
        check("retry_err_clear", err, 0);
        check("retry_busy", busy, 1);
        send_load(32'hA5C31E7F, 8'h07, -1);

        // Reload to a different key.
        start_pulse();
        check("reload_key_clear", key_o, 0);
        send_load(32'h00000001, 8'h01, -1);

        // Timeout after one byte.
        start_pulse();
        sb_q.push_back('{fault: 1'b1, key: '0});
        send_byte(8'h11);
        repeat (TO - 1) tick();
        check("to_before_err", err, 0);
        check("to_before_busy", busy, 1);
        tick();
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_ready", ks_ready, 0);

        // Retry with a TO-1 stall before every byte: must still arm.
        start_pulse();
        begin
            logic [KEY_W-1:0] k;
            logic [7:0] c;
            k = 32'h12345678;
            c = key_xor(k);
            sb_q.push_back('{fault: 1'b0, key: k});
            for (int i = 0; i <= KEY_W / 8; i++) begin
                repeat (TO - 1) tick();
                send_byte(i < KEY_W / 8 ? k[8*i +: 8] : c);
            end
            tick();
            check("stall_kv", key_valid, 1);
            check("stall_key", key_o, k);
        end

        // zeroize with start and a byte offered after the 2nd byte.
        start_pulse();
        send_byte(8'h7F);
        send_byte(8'h1E);
        zeroize  = 1'b1;
        start    = 1'b1;
        ks_valid = 1'b1;
        ks_data  = 8'hC3;
        @(negedge clk);
        check("zero_ready", ks_ready, 0);
        tick();
        zeroize  = 1'b0;
        start    = 1'b0;
        ks_valid = 1'b0;
        check("zero_busy", busy, 0);
        check("zero_key", key_o, 0);
        check("zero_kv", key_valid, 0);
        check("zero_err", err, 0);
        tick();
        check("zero_stays_idle", busy, 0);
        start_pulse();
        send_load(32'hA5C31E7F, 8'h07, -1);

        // zeroize from ARMED.
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_armed_key", key_o, 0);
        check("zero_armed_kv", key_valid, 0);

        // Asynchronous reset mid-load, then a full load with an ignored start.
        start_pulse();
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", ks_ready, 0);
        check("arst_key", key_o, 0);
        check("arst_kv", key_valid, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_idle", busy, 0);
        start_pulse();
        send_load(32'hCAFE0042, key_xor(32'hCAFE0042), 2);

        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
